fan_mode_controller: RTL
========================

FAN_MODE_CONTROLLER -- requirements
Module: fan_mode_controller

Interface
REQ-001 SHALL have parameter PWM_PERIOD, default 100, PWM period in i_clk cycles (at least 4).
REQ-002 SHALL have parameter TICK_DIV, default 100_000, i_clk cycles per timer tick.
REQ-003 SHALL have parameter TIMER_UNIT_TICKS, default 60, ticks per timer unit.
REQ-004 SHALL have port i_clk, input, 1, clock; all logic on the rising edge.
REQ-005 SHALL have port i_reset, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have port i_btn_speed, input, 1, one-cycle pulse from debounced speed button.
REQ-007 SHALL have port i_btn_off, input, 1, one-cycle pulse from debounced off button.
REQ-008 SHALL have port i_btn_timer, input, 1, one-cycle pulse from debounced timer button.
REQ-009 SHALL have port o_pwm, output, 1, fan motor drive.
REQ-010 SHALL have port o_mode, output, 2, current mode: 0 OFF, 1 LOW, 2 MID, 3 HIGH.
REQ-011 SHALL have port o_led, output, 4, one-hot mode indicator: bit n set when o_mode==n.
REQ-012 SHALL have port o_timer_sel, output, 2, timer setting: 0 none, 1 = 1 unit, 2 = 3 units, 3 = 5 units.
REQ-013 SHALL have port o_timer_active, output, 1, high while an auto-off countdown is running.

Function
REQ-014 SHALL implement a mode FSM with states OFF, LOW, MID, HIGH, registered, updating on the cycle after the input pulse.
REQ-015 SHALL advance the mode on i_btn_speed: OFF->LOW->MID->HIGH->LOW, wrapping HIGH to LOW and never returning to OFF.
REQ-016 SHALL enter OFF from any state on i_btn_off; i_btn_off SHALL win over i_btn_speed and i_btn_timer in the same cycle.
REQ-017 SHALL run a PWM counter over 0..PWM_PERIOD-1 that wraps to 0 and runs continuously.
REQ-018 SHALL set target duty per mode: OFF 0, LOW PWM_PERIOD/4, MID PWM_PERIOD/2, HIGH 3*PWM_PERIOD/4, integer truncation.
REQ-019 SHALL load the active duty from the target only when the PWM counter is 0, so no period is truncated.
REQ-020 SHALL drive o_pwm = (PWM counter < active duty), registered, so OFF gives a constant 0.
REQ-021 SHALL have a tick prescaler counting 0..TICK_DIV-1 and emitting a one-cycle tick on wrap.
REQ-022 SHALL advance the timer setting on i_btn_timer while the mode is not OFF: 0->1->2->3->0; the pulse SHALL be ignored in OFF.
REQ-023 SHALL, on a timer setting change, load the remaining counter with units*TIMER_UNIT_TICKS (units 0/1/3/5) and restart the prescaler at 0.
REQ-024 SHALL decrement the remaining counter by one per tick while it is nonzero.
REQ-025 SHALL, when the remaining counter decrements from 1 to 0, set the mode to OFF and o_timer_sel to 0 on the same edge.
REQ-026 SHALL drive o_timer_active = (remaining counter != 0).
REQ-027 SHALL clear the timer setting and remaining counter on any entry to OFF; a speed change SHALL NOT affect the timer.
REQ-028 SHALL, when i_btn_speed coincides with timer expiry, make expiry win: mode OFF.

Reset
REQ-029 SHALL, while i_reset is high, force mode OFF, o_mode 0, o_led 4'b0001, o_pwm 0, o_timer_sel 0, o_timer_active 0, and clear all counters.
REQ-030 SHALL ignore pulses during reset; reset asserted mid-countdown or mid-PWM-period SHALL abort immediately.

Configuration
REQ-031 SHALL include the auto-off timer only when macro FAN_TIMER_EN is defined.
REQ-032 SHALL, without FAN_TIMER_EN, omit the prescaler and remaining counter, ignore i_btn_timer, tie o_timer_sel to 0 and o_timer_active to 0, and keep all other behaviour identical.

Verification (PWM_PERIOD=100, TICK_DIV=10, TIMER_UNIT_TICKS=5, FAN_TIMER_EN defined)
REQ-033 SHALL check: after reset, four i_btn_speed pulses -> o_mode 1,2,3,1; o_led 0010,0100,1000,0010.
REQ-034 SHALL check: MID held 3 periods -> o_pwm high exactly 50 of every 100 cycles; switch to HIGH mid-period -> current period keeps 50, next period 75.
REQ-035 SHALL check: i_btn_speed and i_btn_off in the same cycle from LOW -> o_mode 0, o_pwm 0 from the next period start.
REQ-036 SHALL check: LOW plus one i_btn_timer -> o_timer_sel 1, o_timer_active 1, o_mode 0 exactly 50 cycles later, o_timer_sel 0.
REQ-037 SHALL check: i_btn_timer in OFF -> no change; i_reset asserted mid-countdown -> all outputs at reset values immediately.
REQ-038 SHALL check: FAN_TIMER_EN undefined, i_btn_timer pulses in HIGH -> o_timer_sel 0, o_timer_active 0, mode stays HIGH.

Source files
------------

// File: rtl/fan_mode_controller.sv
`default_nettype none
// =============================================================================
// Module  : fan_mode_controller
// Brief   : Fan speed mode FSM (OFF/LOW/MID/HIGH) with period-aligned PWM
//           drive and an optional auto-off timer, built when FAN_TIMER_EN is
//           defined.
// Revision: 1.0 - initial release
// =============================================================================
module fan_mode_controller #(
  parameter int PWM_PERIOD       = 100,
  parameter int TICK_DIV         = 100_000,
  parameter int TIMER_UNIT_TICKS = 60
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_btn_speed,
  input  logic       i_btn_off,
  input  logic       i_btn_timer,
  output logic       o_pwm,
  output logic [1:0] o_mode,
  output logic [3:0] o_led,
  output logic [1:0] o_timer_sel,
  output logic       o_timer_active
);

  localparam int c_cnt_w = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(PWM_PERIOD - 1);
  localparam logic [c_cnt_w-1:0] c_duty_low  = c_cnt_w'(PWM_PERIOD / 4);
  localparam logic [c_cnt_w-1:0] c_duty_mid  = c_cnt_w'(PWM_PERIOD / 2);
  localparam logic [c_cnt_w-1:0] c_duty_high = c_cnt_w'((3 * PWM_PERIOD) / 4);

  typedef enum logic [1:0] {
    S_OFF  = 2'd0,
    S_LOW  = 2'd1,
    S_MID  = 2'd2,
    S_HIGH = 2'd3
  } mode_t;

  mode_t              r_mode;
  mode_t              w_mode_next;
  logic [c_cnt_w-1:0] r_pwm_cnt;
  logic [c_cnt_w-1:0] r_duty;
  logic [c_cnt_w-1:0] w_target;
  logic [c_cnt_w-1:0] w_duty_eff;
  logic               w_expire;

  // Off button and timer expiry both outrank a speed press.
  always_comb begin
    w_mode_next = r_mode;
    if (i_btn_off || w_expire) begin
      w_mode_next = S_OFF;
    end else if (i_btn_speed) begin
      w_mode_next = (r_mode == S_HIGH) ? S_LOW : mode_t'(r_mode + 2'd1);
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_mode <= S_OFF;
      o_led  <= 4'b0001;
    end else begin
      r_mode <= w_mode_next;
      o_led  <= 4'b0001 << w_mode_next;
    end
  end

  assign o_mode = r_mode;

  always_comb begin
    case (r_mode)
      S_LOW:   w_target = c_duty_low;
      S_MID:   w_target = c_duty_mid;
      S_HIGH:  w_target = c_duty_high;
      default: w_target = '0;
    endcase
  end

  // Duty only changes at the period boundary so no period is cut short.
  assign w_duty_eff = (r_pwm_cnt == '0) ? w_target : r_duty;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_pwm_cnt <= '0;
      r_duty    <= '0;
      o_pwm     <= 1'b0;
    end else begin
      r_pwm_cnt <= (r_pwm_cnt == c_cnt_last) ? '0 : r_pwm_cnt + 1'b1;
      if (r_pwm_cnt == '0) begin
        r_duty <= w_target;
      end
      o_pwm <= (r_pwm_cnt < w_duty_eff);
    end
  end

`ifdef FAN_TIMER_EN
  localparam int c_pre_w = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_rem_w = $clog2(5 * TIMER_UNIT_TICKS + 1);
  localparam logic [c_pre_w-1:0] c_pre_last = c_pre_w'(TICK_DIV - 1);

  logic [c_pre_w-1:0] r_prescale;
  logic [c_rem_w-1:0] r_remaining;
  logic [c_rem_w-1:0] w_load;
  logic [1:0]         r_timer_sel;
  logic [1:0]         w_sel_next;
  logic               w_tick;
  logic               w_sel_change;

  assign w_tick       = (r_prescale == c_pre_last);
  assign w_expire     = w_tick && (r_remaining == c_rem_w'(1));
  assign w_sel_change = i_btn_timer && (r_mode != S_OFF);
  assign w_sel_next   = r_timer_sel + 2'd1;

  always_comb begin
    case (w_sel_next)
      2'd1:    w_load = c_rem_w'(TIMER_UNIT_TICKS);
      2'd2:    w_load = c_rem_w'(3 * TIMER_UNIT_TICKS);
      2'd3:    w_load = c_rem_w'(5 * TIMER_UNIT_TICKS);
      default: w_load = '0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_prescale  <= '0;
      r_remaining <= '0;
      r_timer_sel <= 2'd0;
    end else begin
      r_prescale <= w_tick ? '0 : r_prescale + 1'b1;
      if (i_btn_off || w_expire) begin
        r_remaining <= '0;
        r_timer_sel <= 2'd0;
      end else if (w_sel_change) begin
        r_timer_sel <= w_sel_next;
        r_remaining <= w_load;
        r_prescale  <= '0;
      end else if (w_tick && (r_remaining != '0)) begin
        r_remaining <= r_remaining - 1'b1;
      end
    end
  end

  assign o_timer_sel    = r_timer_sel;
  assign o_timer_active = (r_remaining != '0);
`else
  logic w_unused_timer;

  assign w_unused_timer = i_btn_timer;
  assign w_expire       = 1'b0;
  assign o_timer_sel    = 2'd0;
  assign o_timer_active = 1'b0;
`endif

endmodule
`default_nettype wire
